// File: rtl/axis_packet_rr_arbiter_if.sv
// Bundle of the per-source AXI-Stream inputs, the shared sink output and
// the arbiter status outputs.
//   slave  : arbiter side (takes s_*, m_ready; drives s_ready, m_*, grant, busy)
//   master : environment side (the opposite directions)
interface axis_arb_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_BYTE_WIDTH = DATA_WIDTH/8,
    parameter int NUM_SRC         = 4,
    parameter int IDX_WIDTH       = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0]                 s_valid;
    logic [NUM_SRC*DATA_WIDTH-1:0]      s_data;
    logic [NUM_SRC*DATA_BYTE_WIDTH-1:0] s_keep;
    logic [NUM_SRC-1:0]                 s_last;
    logic [NUM_SRC-1:0]                 s_ready;
    logic                               m_valid;
    logic [DATA_WIDTH-1:0]              m_data;
    logic [DATA_BYTE_WIDTH-1:0]         m_keep;
    logic                               m_last;
    logic                               m_ready;
    logic [IDX_WIDTH-1:0]               grant;
    logic                               busy;

    modport slave (
        input  s_valid, s_data, s_keep, s_last, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last, grant, busy
    );

    modport master (
        output s_valid, s_data, s_keep, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last, grant, busy
    );
endinterface

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream sink between
// NUM_SRC masters. The granted source owns the sink until its tlast beat
// handshakes; the datapath is a zero-latency mux. Each packet costs one
// idle (arbitration) cycle.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : axis_arb_if.slave (s_* sources, m_* sink, grant, busy)
//   pkt_count  : per-source 16-bit completed-packet counters, slice i at
//                [i*16 +: 16]; present only with AXIS_ARB_PKT_CNT_EN defined
//
// State  | meaning
// IDLE   | no owner; pick next requester starting at the rr pointer
// LOCKED | grant owns the sink until its tlast handshakes
module axis_packet_rr_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_BYTE_WIDTH = DATA_WIDTH/8,
    parameter int NUM_SRC         = 4,
    parameter int IDX_WIDTH       = $clog2(NUM_SRC)
) (
    input  logic     clk,
    input  logic     rst_n,
    axis_arb_if.slave bus
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    output logic [NUM_SRC*16-1:0] pkt_count
`endif
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0] grant_q, grant_d;
    logic                 done;

    // (a + k) mod NUM_SRC, valid for a < NUM_SRC and k <= NUM_SRC
    function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] a,
                                                      input int k);
        int s;
        s = int'(a) + k;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return IDX_WIDTH'(s);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        logic [IDX_WIDTH-1:0] cand;
        logic                 found;
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cand        = '0;
        found       = 1'b0;
        done        = 1'b0;
        bus.s_ready = '0;
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        bus.m_keep  = '0;
        bus.m_last  = 1'b0;
        bus.busy    = 1'b0;
        case (state_q)
            IDLE: begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    cand = wrap_add(ptr_q, k);
                    if (!found && bus.s_valid[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                    end
                end
                if (found) state_d = LOCKED;
            end
            LOCKED: begin
                bus.busy             = 1'b1;
                bus.m_valid          = bus.s_valid[grant_q];
                bus.m_data           = bus.s_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
                bus.m_keep           = bus.s_keep[grant_q*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH];
                bus.m_last           = bus.s_last[grant_q];
                bus.s_ready[grant_q] = bus.m_ready;
                done = bus.m_valid & bus.m_ready & bus.m_last;
                if (done) begin
                    state_d = IDLE;
                    ptr_d   = wrap_add(grant_q, 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant = grant_q;

`ifdef AXIS_ARB_PKT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else if (done) begin
            pkt_count[grant_q*16 +: 16] <= pkt_count[grant_q*16 +: 16] + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Directed bench for axis_packet_rr_arbiter: four packet sources modelled
// in the bench, checked with immediate assertions against hand-computed values.
module tb_axis_packet_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    axis_arb_if #(.DATA_WIDTH(32), .NUM_SRC(4)) bus ();

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [63:0] pkt_count;
`endif

    axis_packet_rr_arbiter #(.DATA_WIDTH(32), .NUM_SRC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef AXIS_ARB_PKT_CNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    int          en   [4];
    int          hold [4];
    int          len  [4];
    int          npk  [4];
    int          beat [4];
    logic [15:0] exp_cnt [4];

    function automatic logic [31:0] dval(input int i, input int b);
        return 32'hD000_0000 | 32'(i << 8) | 32'(b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.s_valid[i]        = (en[i] != 0) && (hold[i] == 0);
            bus.s_data[i*32 +: 32] = dval(i, beat[i]);
            bus.s_keep[i*4 +: 4]  = (beat[i] == len[i]-1) ? 4'h7 : 4'hF;
            bus.s_last[i]         = (beat[i] == len[i]-1);
        end
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 4; i++) begin
            en[i] = 0; hold[i] = 0; len[i] = 1; npk[i] = 0; beat[i] = 0;
            exp_cnt[i] = 16'd0;
        end
    endtask

    // one clock: handshakes seen before the edge advance the source models
    task automatic step();
        logic [3:0] hs;
        hs = bus.s_valid & bus.s_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                if (beat[i] == len[i]-1) begin
                    beat[i] = 0;
                    npk[i]--;
                    exp_cnt[i]++;
                    if (npk[i] == 0) en[i] = 0;
                end else begin
                    beat[i]++;
                end
            end
        end
        settle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_srcs();
        settle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic src(input int i, input int l, input int n);
        en[i] = 1; len[i] = l; npk[i] = n; beat[i] = 0; hold[i] = 0;
    endtask

    initial begin
        int gseq [5];
        gseq = '{0, 1, 2, 3, 0};
        rst_n       = 1'b0;
        bus.m_ready = 1'b0;
        clear_srcs();
        settle();
        #10;
        chk("rst_busy",    64'(bus.busy),    64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_grant",   64'(bus.grant),   64'd0);
        chk("rst_m_data",  64'(bus.m_data),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // 1: idle with no requests
        for (int c = 0; c < 4; c++) begin
            step();
            chk("idle_busy",    64'(bus.busy),    64'd0);
            chk("idle_m_valid", 64'(bus.m_valid), 64'd0);
            chk("idle_s_ready", 64'(bus.s_ready), 64'd0);
        end

        // 2: src0 and src2, 3-beat packets
        bus.m_ready = 1'b1;
        src(0, 3, 1);
        src(2, 3, 1);
        settle();
        chk("t2_arb_m_valid", 64'(bus.m_valid), 64'd0);
        step();
        chk("t2_grant0",   64'(bus.grant),   64'd0);
        chk("t2_s_ready0", 64'(bus.s_ready), 64'b0001);
        chk("t2_d0b0",     64'(bus.m_data),  64'(dval(0, 0)));
        chk("t2_last0b0",  64'(bus.m_last),  64'd0);
        step();
        chk("t2_d0b1",     64'(bus.m_data),  64'(dval(0, 1)));
        step();
        chk("t2_d0b2",     64'(bus.m_data),  64'(dval(0, 2)));
        chk("t2_last0b2",  64'(bus.m_last),  64'd1);
        chk("t2_keep0b2",  64'(bus.m_keep),  64'h7);
        step();
        chk("t2_gap_busy",    64'(bus.busy),    64'd0);
        chk("t2_gap_m_valid", 64'(bus.m_valid), 64'd0);
        step();
        chk("t2_grant2",   64'(bus.grant),   64'd2);
        chk("t2_s_ready2", 64'(bus.s_ready), 64'b0100);
        chk("t2_d2b0",     64'(bus.m_data),  64'(dval(2, 0)));
        step();
        step();
        chk("t2_d2b2",     64'(bus.m_data),  64'(dval(2, 2)));
        step();
        chk("t2_end_busy", 64'(bus.busy),    64'd0);
`ifdef AXIS_ARB_PKT_CNT_EN
        chk("t2_cnt", 64'(pkt_count), {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]});
`endif

        // 3: all sources, single-beat packets, pointer wraps 3 -> 0
        do_reset();
        src(0, 1, 2);
        src(1, 1, 1);
        src(2, 1, 1);
        src(3, 1, 1);
        settle();
        for (int p = 0; p < 5; p++) begin
            step();
            chk("t3_grant",  64'(bus.grant),  64'(gseq[p]));
            chk("t3_busy",   64'(bus.busy),   64'd1);
            chk("t3_m_last", 64'(bus.m_last), 64'd1);
            step();
            chk("t3_gap",    64'(bus.busy),   64'd0);
        end
        step();
        chk("t3_quiet",  64'(bus.busy), 64'd0);

        // 4: src1 4-beat packet with back-pressure
        src(1, 4, 1);
        bus.m_ready = 1'b1;
        settle();
        step();
        chk("t4_grant1",   64'(bus.grant),   64'd1);
        chk("t4_d1b0",     64'(bus.m_data),  64'(dval(1, 0)));
        chk("t4_rdy_on",   64'(bus.s_ready), 64'b0010);
        step();
        bus.m_ready = 1'b0;
        settle();
        chk("t4_rdy_off",  64'(bus.s_ready), 64'b0000);
        chk("t4_valid",    64'(bus.m_valid), 64'd1);
        chk("t4_d1b1",     64'(bus.m_data),  64'(dval(1, 1)));
        step();
        chk("t4_d1b1_held", 64'(bus.m_data), 64'(dval(1, 1)));
        bus.m_ready = 1'b1;
        settle();
        chk("t4_rdy_on2",  64'(bus.s_ready), 64'b0010);
        step();
        bus.m_ready = 1'b0;
        settle();
        chk("t4_d1b2",     64'(bus.m_data),  64'(dval(1, 2)));
        chk("t4_rdy_off2", 64'(bus.s_ready), 64'b0000);
        step();
        bus.m_ready = 1'b1;
        settle();
        step();
        chk("t4_last",     64'(bus.m_last),  64'd1);
        bus.m_ready = 1'b0;
        settle();
        step();
        chk("t4_last_held", 64'(bus.m_last), 64'd1);
        chk("t4_busy_held", 64'(bus.busy),   64'd1);
        bus.m_ready = 1'b1;
        settle();
        step();
        chk("t4_end_busy", 64'(bus.busy),    64'd0);

        // 5: owner src2 stalls mid-packet while src3 requests
        src(2, 3, 1);
        src(3, 2, 1);
        settle();
        step();
        chk("t5_grant2", 64'(bus.grant), 64'd2);
        step();
        hold[2] = 1;
        settle();
        chk("t5_stall_valid", 64'(bus.m_valid), 64'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t5_stall_grant", 64'(bus.grant),   64'd2);
            chk("t5_stall_valid", 64'(bus.m_valid), 64'd0);
            chk("t5_stall_rdy",   64'(bus.s_ready), 64'b0100);
        end
        hold[2] = 0;
        settle();
        chk("t5_d2b1", 64'(bus.m_data), 64'(dval(2, 1)));
        step();
        chk("t5_last", 64'(bus.m_last), 64'd1);
        step();
        chk("t5_gap",  64'(bus.busy),   64'd0);
        step();
        chk("t5_grant3", 64'(bus.grant), 64'd3);
        chk("t5_d3b0",   64'(bus.m_data), 64'(dval(3, 0)));
        step();
        step();
        chk("t5_end_busy", 64'(bus.busy), 64'd0);

        // 6: reset mid-packet, pointer returns to 0
        src(1, 1, 1);
        settle();
        step();
        chk("t6_pre_grant", 64'(bus.grant), 64'd1);
        step();
        src(1, 4, 1);
        settle();
        step();
        step();
        chk("t6_b1_valid", 64'(bus.m_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy",    64'(bus.busy),    64'd0);
        chk("t6_rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("t6_rst_m_data",  64'(bus.m_data),  64'd0);
        chk("t6_rst_m_last",  64'(bus.m_last),  64'd0);
        chk("t6_rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("t6_rst_grant",   64'(bus.grant),   64'd0);
`ifdef AXIS_ARB_PKT_CNT_EN
        chk("t6_rst_cnt",     64'(pkt_count),   64'd0);
`endif
        do_reset();
        src(1, 1, 1);
        src(3, 1, 1);
        settle();
        step();
        chk("t6_restart_grant", 64'(bus.grant), 64'd1);
        step();
        step();
        chk("t6_next_grant",    64'(bus.grant), 64'd3);
        step();
        chk("t6_end_busy",      64'(bus.busy),  64'd0);
`ifdef AXIS_ARB_PKT_CNT_EN
        chk("t6_cnt", 64'(pkt_count), {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
